// File: rtl/nrf_irq_pkg.sv
// Shared types for the nRF24L01 IRQ sequencer: FSM states, PIO register map
// and the per-state PIO bus command.
package nrf_irq_pkg;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_INIT_MASK,
    ST_INIT_CLR,
    ST_ARMED,
    ST_RD_CAP,
    ST_RD_CAP_W,
    ST_CLR_CAP,
    ST_REQ,
    ST_WAIT_DONE,
    ST_RD_PIN,
    ST_RD_PIN_W,
    ST_DIS_MASK
  } state_t;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  typedef struct packed {
    logic        cs;
    logic        write_n;
    logic [1:0]  addr;
    logic [31:0] wdata;
  } pio_cmd_t;

  // Bus cycle presented while the FSM sits in state s.
  function automatic pio_cmd_t pio_cmd(state_t s);
    pio_cmd_t c;
    c.cs      = 1'b0;
    c.write_n = 1'b1;
    c.addr    = ADDR_DATA;
    c.wdata   = 32'd0;
    case (s)
      ST_INIT_MASK: begin c.cs = 1'b1; c.write_n = 1'b0; c.addr = ADDR_MASK; c.wdata = 32'd1; end
      ST_INIT_CLR:  begin c.cs = 1'b1; c.write_n = 1'b0; c.addr = ADDR_EDGE; end
      ST_RD_CAP:    begin c.cs = 1'b1; c.addr = ADDR_EDGE; end
      ST_CLR_CAP:   begin c.cs = 1'b1; c.write_n = 1'b0; c.addr = ADDR_EDGE; end
      ST_RD_PIN:    begin c.cs = 1'b1; c.addr = ADDR_DATA; end
      ST_DIS_MASK:  begin c.cs = 1'b1; c.write_n = 1'b0; c.addr = ADDR_MASK; end
      default:      ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/nrf_irq_sequencer.sv
// Avalon-MM master that services nRF24L01 IRQs through the edge-capture PIO
// and hands each event to the SPI command engine.
module nrf_irq_sequencer
  import nrf_irq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  output logic [1:0]       pio_address,
  output logic             pio_chipselect,
  output logic             pio_write_n,
  output logic [31:0]      pio_writedata,
  input  logic [31:0]      pio_readdata,
  input  logic             pio_irq,
  output logic             svc_req,
  input  logic             svc_ack,
  input  logic             svc_done,
  input  logic             err_clr,
  output logic             busy,
  output logic             timeout_err,
  output logic [CNT_W-1:0] event_count,
  output logic [CNT_W-1:0] spurious_count
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t          state;
  state_t          state_nxt;
  pio_cmd_t        cmd_nxt;
  logic [TMO_W-1:0] tmo_cnt;
  logic            tmo_hit;
  logic            ack_evt;
  logic            spur_evt;
  logic            tmo_evt;
  logic            unused_rd;

  assign unused_rd = ^pio_readdata[31:1];
  assign tmo_hit   = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign cmd_nxt   = pio_cmd(state_nxt);
  assign busy      = !(state == ST_OFF || state == ST_ARMED);

  always_comb begin
    state_nxt = state;
    ack_evt   = 1'b0;
    spur_evt  = 1'b0;
    tmo_evt   = 1'b0;
    case (state)
      ST_OFF:       if (enable) state_nxt = ST_INIT_MASK;
      ST_INIT_MASK: state_nxt = ST_INIT_CLR;
      ST_INIT_CLR:  state_nxt = ST_ARMED;
      // Disable takes priority so a pending edge is dropped with the mask.
      ST_ARMED: begin
        if (!enable)      state_nxt = ST_DIS_MASK;
        else if (pio_irq) state_nxt = ST_RD_CAP;
      end
      ST_RD_CAP:    state_nxt = ST_RD_CAP_W;
      ST_RD_CAP_W: begin
        if (pio_readdata[0]) begin
          state_nxt = ST_CLR_CAP;
        end else begin
          spur_evt  = 1'b1;
          state_nxt = ST_ARMED;
        end
      end
      ST_CLR_CAP:   state_nxt = ST_REQ;
      ST_REQ: begin
        if (svc_ack) begin
          ack_evt   = 1'b1;
          state_nxt = ST_WAIT_DONE;
        end
      end
      ST_WAIT_DONE: begin
        if (svc_done) begin
          state_nxt = ST_RD_PIN;
        end else if (tmo_hit) begin
          tmo_evt   = 1'b1;
          state_nxt = ST_RD_PIN;
        end
      end
      ST_RD_PIN:    state_nxt = ST_RD_PIN_W;
      // Pin still low means the radio raised another event while we were busy.
      ST_RD_PIN_W:  state_nxt = (!pio_readdata[0] && enable) ? ST_REQ : ST_ARMED;
      ST_DIS_MASK:  state_nxt = ST_OFF;
      default:      state_nxt = ST_OFF;
    endcase
  end

  // Bus outputs are registered from the next state so they line up with the state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= ST_OFF;
      pio_chipselect <= 1'b0;
      pio_write_n    <= 1'b1;
      pio_address    <= ADDR_DATA;
      pio_writedata  <= 32'd0;
      svc_req        <= 1'b0;
    end else begin
      state          <= state_nxt;
      pio_chipselect <= cmd_nxt.cs;
      pio_write_n    <= cmd_nxt.write_n;
      pio_address    <= cmd_nxt.addr;
      pio_writedata  <= cmd_nxt.wdata;
      svc_req        <= (state_nxt == ST_REQ);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt        <= '0;
      timeout_err    <= 1'b0;
      event_count    <= '0;
      spurious_count <= '0;
    end else begin
      if (state != ST_WAIT_DONE)
        tmo_cnt <= '0;
      else
        tmo_cnt <= tmo_cnt + TMO_W'(1);
      if (tmo_evt)
        timeout_err <= 1'b1;
      else if (err_clr)
        timeout_err <= 1'b0;
      if (ack_evt)
        event_count <= event_count + CNT_W'(1);
      if (spur_evt)
        spurious_count <= spurious_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_nrf_irq_sequencer.sv
// Bench for nrf_irq_sequencer: edge-capture PIO model, behavioural scoreboard
// for counters/timeout, and directed scenarios with literal expectations.
module tb_nrf_irq_sequencer;

  localparam int TMO   = 16;
  localparam int CNT_W = 16;

  logic             clk;
  logic             reset_n;
  logic             enable;
  logic [1:0]       pio_address;
  logic             pio_chipselect;
  logic             pio_write_n;
  logic [31:0]      pio_writedata;
  logic [31:0]      pio_readdata;
  logic             pio_irq;
  logic             svc_req;
  logic             svc_ack;
  logic             svc_done;
  logic             err_clr;
  logic             busy;
  logic             timeout_err;
  logic [CNT_W-1:0] event_count;
  logic [CNT_W-1:0] spurious_count;

  nrf_irq_sequencer #(.TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .svc_req(svc_req), .svc_ack(svc_ack), .svc_done(svc_done),
    .err_clr(err_clr), .busy(busy), .timeout_err(timeout_err),
    .event_count(event_count), .spurious_count(spurious_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // PIO slave model: nRF IRQ pin (active low), edge capture, mask, 1-cycle read latency.
  logic pin, pin_q, cap, mask, force_irq;
  assign pio_irq = (cap & mask) | force_irq;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pin_q <= 1'b1; cap <= 1'b0; mask <= 1'b0; pio_readdata <= 32'd0;
    end else begin
      pin_q <= pin;
      if (pio_chipselect && pio_write_n)
        case (pio_address)
          2'd0:    pio_readdata <= {31'd0, pin};
          2'd2:    pio_readdata <= {31'd0, mask};
          2'd3:    pio_readdata <= {31'd0, cap};
          default: pio_readdata <= 32'd0;
        endcase
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) mask <= pio_writedata[0];
      if (pio_chipselect && !pio_write_n && pio_address == 2'd3) cap <= 1'b0;
      if (pin_q && !pin) cap <= 1'b1;
    end
  end

  logic [1:0]  wr_addr_q[$];
  logic [31:0] wr_data_q[$];
  always @(posedge clk)
    if (reset_n && pio_chipselect && !pio_write_n) begin
      wr_addr_q.push_back(pio_address);
      wr_data_q.push_back(pio_writedata);
    end

  // Scoreboard: counts handshakes, edge-capture reads returning 0, and the
  // done-or-timeout window opened by each accepted request.
  int unsigned      m_w;
  logic             m_wait, m_err, m_rdcap;
  logic [CNT_W-1:0] m_ev, m_sp;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_w <= 0; m_wait <= 1'b0; m_err <= 1'b0; m_rdcap <= 1'b0; m_ev <= '0; m_sp <= '0;
    end else begin
      logic set_err;
      set_err = 1'b0;
      if (svc_req && svc_ack) begin
        m_ev <= m_ev + 1'b1; m_wait <= 1'b1; m_w <= 0;
      end else if (m_wait) begin
        if (svc_done) m_wait <= 1'b0;
        else if (m_w + 1 == TMO) begin m_wait <= 1'b0; set_err = 1'b1; end
        else m_w <= m_w + 1;
      end
      if (set_err) m_err <= 1'b1;
      else if (err_clr) m_err <= 1'b0;
      m_rdcap <= pio_chipselect && pio_write_n && pio_address == 2'd3;
      if (m_rdcap && !pio_readdata[0]) m_sp <= m_sp + 1'b1;
    end
  end

  always @(negedge clk)
    if (reset_n) begin
      check("event_count_model", event_count, m_ev);
      check("spurious_count_model", spurious_count, m_sp);
      check("timeout_err_model", timeout_err, m_err);
    end

  task automatic wait_req(input string nm, output int n);
    n = 0;
    while (!svc_req && n < 50) begin @(negedge clk); n++; end
    check(nm, svc_req, 1'b1);
  endtask

  task automatic do_ack();
    svc_ack = 1'b1;
    @(negedge clk);
    svc_ack = 1'b0;
    check("svc_req_drop_after_ack", svc_req, 1'b0);
  endtask

  task automatic do_done();
    svc_done = 1'b1;
    @(negedge clk);
    svc_done = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) @(negedge clk);
  endtask

  task automatic watch_no_req(input string nm, input int k);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < k; i++) begin @(negedge clk); if (svc_req) seen = 1'b1; end
    check(nm, seen, 1'b0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cs"}, pio_chipselect, 1'b0);
    check({tag, "_write_n"}, pio_write_n, 1'b1);
    check({tag, "_addr"}, pio_address, 2'd0);
    check({tag, "_wdata"}, pio_writedata, 32'd0);
    check({tag, "_svc_req"}, svc_req, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_timeout_err"}, timeout_err, 1'b0);
    check({tag, "_event_count"}, event_count, 0);
    check({tag, "_spurious_count"}, spurious_count, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset_n = 1'b0; enable = 1'b0; pin = 1'b1; force_irq = 1'b0;
    svc_ack = 1'b0; svc_done = 1'b0; err_clr = 1'b0;
    idle(3);
    check_reset_vals("reset");
    reset_n = 1'b1;
    idle(2);

    // Bring-up: mask write then edge clear, ARMED after 3 clocks.
    wr_addr_q.delete(); wr_data_q.delete();
    enable = 1'b1;
    @(negedge clk); check("init_busy_1", busy, 1'b1);
    @(negedge clk); check("init_busy_2", busy, 1'b1);
    @(negedge clk); check("armed_busy", busy, 1'b0);
    check("init_wr_count", wr_addr_q.size(), 2);
    if (wr_addr_q.size() == 2) begin
      check("init_wr0_addr", wr_addr_q[0], 2'd2);
      check("init_wr0_data", wr_data_q[0], 32'd1);
      check("init_wr1_addr", wr_addr_q[1], 2'd3);
      check("init_wr1_data", wr_data_q[1], 32'd0);
    end
    check("init_mask", mask, 1'b1);

    // Single event: irq to svc_req in exactly 4 clocks.
    pin = 1'b0;
    n = 0;
    while (!pio_irq && n < 10) begin @(negedge clk); n++; end
    check("irq_seen", pio_irq, 1'b1);
    n = 0;
    while (!svc_req && n < 20) begin @(posedge clk); @(negedge clk); n++; end
    check("irq_to_req_clocks", n, 4);
    do_ack();
    pin = 1'b1;
    idle(2);
    do_done();
    idle(4);
    check("ev1_busy", busy, 1'b0);
    check("ev1_event_count", event_count, 1);
    check("ev1_edge_cap", cap, 1'b0);

    // New edge, pin held low across done: second request without a new edge.
    pin = 1'b0;
    wait_req("ev2_req", n);
    do_ack();
    idle(2);
    do_done();
    wait_req("ev3_rereq", n);
    check("ev3_rereq_clocks", n, 2);
    check("ev3_no_new_edge", cap, 1'b0);
    do_ack();
    pin = 1'b1;
    do_done();
    idle(4);
    check("ev3_event_count", event_count, 3);
    check("ev3_busy", busy, 1'b0);

    // Ack without done: timeout after TMO clocks, then err_clr.
    pin = 1'b0;
    wait_req("tmo_req", n);
    do_ack();
    pin = 1'b1;
    n = 0;
    while (!timeout_err && n < 40) begin @(negedge clk); n++; end
    check("tmo_clocks", n, TMO);
    check("tmo_err_set", timeout_err, 1'b1);
    idle(4);
    check("tmo_back_armed", busy, 1'b0);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("tmo_err_cleared", timeout_err, 1'b0);

    // err_clr held through the timeout edge: set must win.
    pin = 1'b0;
    wait_req("tmo2_req", n);
    do_ack();
    pin = 1'b1;
    err_clr = 1'b1;
    n = 0;
    while (!timeout_err && n < 40) begin @(negedge clk); n++; end
    err_clr = 1'b0;
    check("tmo2_clocks", n, TMO);
    @(negedge clk);
    check("tmo2_err_sticky", timeout_err, 1'b1);
    idle(3);
    err_clr = 1'b1; @(negedge clk); err_clr = 1'b0;
    check("tmo2_err_cleared", timeout_err, 1'b0);

    // Spurious irq: edge capture reads 0.
    force_irq = 1'b1; @(negedge clk); force_irq = 1'b0;
    watch_no_req("spur_no_req", 8);
    check("spur_count", spurious_count, 1);
    check("spur_event_count", event_count, 5);

    // Disable with a simultaneous irq: mask off, no service.
    wr_addr_q.delete(); wr_data_q.delete();
    pin = 1'b0;
    @(negedge clk);
    check("dis_irq_pending", pio_irq, 1'b1);
    enable = 1'b0;
    watch_no_req("dis_no_req", 8);
    check("dis_wr_count", wr_addr_q.size(), 1);
    if (wr_addr_q.size() == 1) begin
      check("dis_wr_addr", wr_addr_q[0], 2'd2);
      check("dis_wr_data", wr_data_q[0], 32'd0);
    end
    check("dis_mask", mask, 1'b0);
    check("dis_busy", busy, 1'b0);
    check("dis_event_count", event_count, 5);
    pin = 1'b1;

    // Re-enable, then reset in the middle of WAIT_DONE.
    enable = 1'b1;
    idle(5);
    check("reen_busy", busy, 1'b0);
    pin = 1'b0;
    wait_req("rst_req", n);
    do_ack();
    idle(2);
    check("rst_busy_wait", busy, 1'b1);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    enable = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
